// File: rtl/present_key_scheduler.sv
// PRESENT-80 key schedule sequencer: loads an 80-bit user key, then streams
// round keys K1..K32 with their round index over a valid/ready handshake.
module present_key_scheduler #(
    parameter int unsigned KEY_W  = 80,
    parameter int unsigned RK_W   = 64,
    parameter int unsigned NUM_RK = 32
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [KEY_W-1:0]          i_key_in,
    input  logic                      i_key_valid,
    output logic                      o_key_ready,
    output logic [RK_W-1:0]           o_rk_data,
    output logic [$clog2(NUM_RK)-1:0] o_rk_round,
    output logic                      o_rk_valid,
    input  logic                      i_rk_ready,
    output logic                      o_busy,
    output logic                      o_done
);

    localparam int unsigned RND_W = $clog2(NUM_RK);
    localparam logic [RND_W-1:0] LAST_RND = RND_W'(NUM_RK - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             r_state;
    logic [KEY_W-1:0]   r_key;
    logic [RND_W-1:0]   r_rnd;

    state_e             w_state_d;
    logic [KEY_W-1:0]   w_key_d;
    logic [RND_W-1:0]   w_rnd_d;
    logic               w_hs_rk;

    // PRESENT 4-bit S-box.
    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        unique case (x)
            4'h0: y = 4'hc;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hb;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'ha;
            4'h7: y = 4'hd;
            4'h8: y = 4'h3;
            4'h9: y = 4'he;
            4'ha: y = 4'hf;
            4'hb: y = 4'h8;
            4'hc: y = 4'h4;
            4'hd: y = 4'h7;
            4'he: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    // One key-register update step: rotate left 61, S-box top nibble, xor round counter.
    function automatic logic [79:0] key_update(input logic [79:0] k, input logic [4:0] r);
        logic [79:0] t;
        t          = {k[18:0], k[79:19]};
        t[79:76]   = sbox(t[79:76]);
        t[19:15]   = t[19:15] ^ r;
        return t;
    endfunction

    // Outputs are forced inactive while reset is held so nothing leaks mid-abort.
    always_comb begin
        o_key_ready = i_rst_n && (r_state == StIdle);
        o_rk_valid  = i_rst_n && (r_state == StRun);
        o_busy      = i_rst_n && (r_state == StRun);
        o_done      = i_rst_n && (r_state == StDone);
        o_rk_data   = r_key[KEY_W-1 -: RK_W];
        o_rk_round  = r_rnd;
    end

    assign w_hs_rk = o_rk_valid && i_rk_ready;

    // Next-state, key register and round counter updates.
    always_comb begin
        w_state_d = r_state;
        w_key_d   = r_key;
        w_rnd_d   = r_rnd;
        unique case (r_state)
            StIdle: begin
                if (i_key_valid) begin
                    w_key_d   = i_key_in;
                    w_rnd_d   = RND_W'(1);
                    w_state_d = StRun;
                end
            end
            StRun: begin
                if (w_hs_rk) begin
                    if (r_rnd == '0) begin
                        // K32 just consumed.
                        w_state_d = StDone;
                    end else begin
                        w_key_d = key_update(r_key, r_rnd);
                        // Round 31 wraps to 0, which marks K32.
                        w_rnd_d = (r_rnd == LAST_RND) ? '0 : r_rnd + RND_W'(1);
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_key   <= '0;
            r_rnd   <= RND_W'(1);
        end else begin
            r_state <= w_state_d;
            r_key   <= w_key_d;
            r_rnd   <= w_rnd_d;
        end
    end

endmodule

// File: tb/tb_present_key_scheduler.sv
// Directed testbench for present_key_scheduler.
module tb_present_key_scheduler;

    logic        clk;
    logic        rst_n;
    logic [79:0] key_in;
    logic        key_valid;
    logic        key_ready;
    logic [63:0] rk_data;
    logic [4:0]  rk_round;
    logic        rk_valid;
    logic        rk_ready;
    logic        busy;
    logic        done;

    int n_checks;
    int n_fail;

    // Stream capture results.
    logic [63:0] c_keys [32];
    logic [4:0]  c_rnds [32];
    int          c_nhs;
    int          c_done_cnt;
    int          c_done_gap;
    bit          c_timeout;
    bit          c_stall_bad;
    bit          c_kr_bad;
    bit          c_busy_bad;
    bit          l_timeout;

    // Golden stream.
    logic [63:0] e_keys [32];
    logic [4:0]  e_rnds [32];

    present_key_scheduler dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_key_in    (key_in),
        .i_key_valid (key_valid),
        .o_key_ready (key_ready),
        .o_rk_data   (rk_data),
        .o_rk_round  (rk_round),
        .o_rk_valid  (rk_valid),
        .i_rk_ready  (rk_ready),
        .o_busy      (busy),
        .o_done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Software PRESENT-80 key schedule, written bit by bit.
    function automatic logic [79:0] m_update(input logic [79:0] k, input logic [4:0] r);
        logic [79:0] t;
        logic [63:0] stab;
        logic [3:0]  idx;
        stab = 64'hc56b90ad3ef84712;
        for (int i = 0; i < 80; i++) t[(i + 61) % 80] = k[i];
        idx = t[79:76];
        t[79:76] = stab[(15 - idx) * 4 +: 4];
        for (int i = 0; i < 5; i++) t[15 + i] = t[15 + i] ^ r[i];
        return t;
    endfunction

    task automatic build_golden(input logic [79:0] k);
        logic [79:0] kr;
        kr = k;
        for (int i = 0; i < 32; i++) begin
            e_keys[i] = kr[79:16];
            e_rnds[i] = (i == 31) ? 5'd0 : 5'(i + 1);
            if (i < 31) kr = m_update(kr, 5'(i + 1));
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Offer a key and wait (bounded) for the handshake edge.
    task automatic load_key(input logic [79:0] k, input bit hold);
        bit got;
        got = 0;
        key_in = k;
        key_valid = 1'b1;
        for (int i = 0; i < 60 && !got; i++) begin
            if (key_ready) got = 1;
            tick();
        end
        l_timeout = !got;
        if (!hold) key_valid = 1'b0;
    endtask

    // Consume the round-key stream until done, recording handshakes and anomalies.
    task automatic collect(input bit rand_ready);
        int          cyc;
        int          last_hs;
        bit          stalled;
        bit          fin;
        logic [63:0] held_d;
        logic [4:0]  held_r;
        c_nhs = 0; c_done_cnt = 0; c_done_gap = -1; c_timeout = 1;
        c_stall_bad = 0; c_kr_bad = 0; c_busy_bad = 0;
        cyc = 0; last_hs = -100; stalled = 0; fin = 0;
        held_d = '0; held_r = '0;
        while (!fin && cyc < 2000) begin
            if (stalled && (rk_valid !== 1'b1 || rk_data !== held_d || rk_round !== held_r))
                c_stall_bad = 1;
            if (key_ready && (rk_valid || done)) c_kr_bad = 1;
            if (busy !== rk_valid) c_busy_bad = 1;
            if (done) begin
                c_done_cnt++;
                c_done_gap = cyc - last_hs;
                c_timeout = 0;
                fin = 1;
            end else begin
                rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                if (rk_valid && rk_ready) begin
                    if (c_nhs < 32) begin
                        c_keys[c_nhs] = rk_data;
                        c_rnds[c_nhs] = rk_round;
                    end
                    c_nhs++;
                    last_hs = cyc;
                    stalled = 0;
                end else if (rk_valid) begin
                    stalled = 1;
                    held_d = rk_data;
                    held_r = rk_round;
                end
                tick();
                cyc++;
            end
        end
        rk_ready = 1'b1;
    endtask

    // Compare a captured stream against the golden stream.
    task automatic check_stream(input string tag);
        int bad;
        bad = 0;
        n_checks++;
        if (c_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_timeout: got timeout=%0b, required 0", tag, c_timeout);
        end
        n_checks++;
        if (c_nhs !== 32) begin
            n_fail++;
            $display("FAIL %s_handshakes: got %0d, required 32", tag, c_nhs);
        end
        for (int i = 0; i < 32; i++) begin
            if (c_keys[i] !== e_keys[i] || c_rnds[i] !== e_rnds[i]) begin
                if (bad == 0)
                    $display("FAIL %s_stream K%0d: got %h/%0d, required %h/%0d", tag, i + 1,
                             c_keys[i], c_rnds[i], e_keys[i], e_rnds[i]);
                bad++;
            end
        end
        n_checks++;
        if (bad != 0) n_fail++;
        n_checks++;
        if (c_done_gap !== 1 || c_done_cnt !== 1) begin
            n_fail++;
            $display("FAIL %s_done: got gap=%0d count=%0d, required gap=1 count=1", tag,
                     c_done_gap, c_done_cnt);
        end
        n_checks++;
        if (c_kr_bad || c_busy_bad) begin
            n_fail++;
            $display("FAIL %s_flags: got key_ready_bad=%0b busy_bad=%0b, required 0/0", tag,
                     c_kr_bad, c_busy_bad);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({key_ready, rk_valid, busy, done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b, required 0000", {key_ready, rk_valid, busy, done});
        end
        n_checks++;
        if (rk_data !== 64'h0 || rk_round !== 5'd1) begin
            n_fail++;
            $display("FAIL reset_regs: got %h/%0d, required 0/1", rk_data, rk_round);
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (key_ready !== 1'b1 || rk_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got ready=%0b valid=%0b, required 1/0", key_ready, rk_valid);
        end
    endtask

    task automatic test_zero_key;
        build_golden(80'h0);
        rk_ready = 1'b1;
        load_key(80'h0, 0);
        n_checks++;
        if (l_timeout || rk_valid !== 1'b1 || rk_data !== 64'h0 || rk_round !== 5'd1) begin
            n_fail++;
            $display("FAIL zero_k1: got valid=%0b %h/%0d, required 1 0000000000000000/1",
                     rk_valid, rk_data, rk_round);
        end
        collect(0);
        n_checks++;
        if (c_keys[1] !== 64'hc000000000000000 || c_rnds[1] !== 5'd2) begin
            n_fail++;
            $display("FAIL zero_k2: got %h/%0d, required c000000000000000/2", c_keys[1], c_rnds[1]);
        end
        n_checks++;
        if (c_keys[31] !== 64'h6dab31744f41d700 || c_rnds[31] !== 5'd0) begin
            n_fail++;
            $display("FAIL zero_k32: got %h/%0d, required 6dab31744f41d700/0",
                     c_keys[31], c_rnds[31]);
        end
        check_stream("zero");
        tick();
        n_checks++;
        if (done !== 1'b0 || key_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_after_done: got done=%0b ready=%0b, required 0/1", done, key_ready);
        end
    endtask

    task automatic test_backpressure;
        build_golden(80'h0);
        load_key(80'h0, 0);
        collect(1);
        n_checks++;
        if (c_stall_bad !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_stall_stable: got unstable=%0b, required 0", c_stall_bad);
        end
        check_stream("bp");
        tick();
    endtask

    task automatic test_back_to_back;
        logic [79:0] k;
        k = {80{1'b1}};
        build_golden(k);
        load_key(k, 1);
        n_checks++;
        if (rk_valid !== 1'b1 || rk_data !== 64'hffffffffffffffff) begin
            n_fail++;
            $display("FAIL b2b_k1: got valid=%0b %h, required 1 ffffffffffffffff", rk_valid, rk_data);
        end
        collect(0);
        check_stream("b2b_first");
        // Key still offered: not taken in the done cycle, taken from IDLE next cycle.
        tick();
        n_checks++;
        if (key_ready !== 1'b1 || rk_valid !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: got ready=%0b valid=%0b done=%0b, required 1/0/0",
                     key_ready, rk_valid, done);
        end
        tick();
        n_checks++;
        if (rk_valid !== 1'b1 || key_ready !== 1'b0 || rk_data !== 64'hffffffffffffffff) begin
            n_fail++;
            $display("FAIL b2b_second_k1: got valid=%0b ready=%0b %h, required 1/0 ffffffffffffffff",
                     rk_valid, key_ready, rk_data);
        end
        collect(0);
        key_valid = 1'b0;
        check_stream("b2b_second");
        tick();
    endtask

    task automatic test_reset_mid_run;
        bit seen;
        bit bad_done;
        seen = 0;
        bad_done = 0;
        rk_ready = 1'b1;
        load_key(80'h0123456789abcdef0123, 0);
        for (int i = 0; i < 40 && !seen; i++) begin
            if (rk_valid && rk_round == 5'd10) seen = 1;
            else tick();
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL rst_mid_reach: got round10_seen=0, required 1");
        end
        rst_n = 1'b0;
        tick();
        n_checks++;
        if (rk_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_abort: got valid=%0b done=%0b busy=%0b, required 0/0/0",
                     rk_valid, done, busy);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done || rk_valid || !key_ready) bad_done = 1;
        end
        n_checks++;
        if (bad_done) begin
            n_fail++;
            $display("FAIL rst_mid_idle: got activity after reset, required idle with key_ready");
        end
        build_golden(80'hfedcba9876543210fedc);
        load_key(80'hfedcba9876543210fedc, 0);
        n_checks++;
        if (rk_round !== 5'd1 || rk_data !== e_keys[0]) begin
            n_fail++;
            $display("FAIL rst_mid_restart: got %h/%0d, required %h/1", rk_data, rk_round, e_keys[0]);
        end
        collect(0);
        check_stream("rst_restart");
        tick();
    endtask

    task automatic test_random_keys;
        logic [79:0] k;
        int          fails_before;
        int          bad_keys;
        bad_keys = 0;
        for (int n = 0; n < 200; n++) begin
            k = {16'($urandom), $urandom, $urandom};
            build_golden(k);
            fails_before = n_fail;
            load_key(k, 0);
            collect(n[0]);
            check_stream("rand");
            if (n_fail != fails_before) bad_keys++;
            tick();
        end
        n_checks++;
        if (bad_keys != 0) begin
            n_fail++;
            $display("FAIL rand_summary: got %0d bad keys, required 0", bad_keys);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        key_in    = '0;
        key_valid = 1'b0;
        rk_ready  = 1'b1;
        #1;
        test_reset();
        test_zero_key();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        test_random_keys();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/present_key_scheduler.md
Name: present_key_scheduler

Overview:
- Sequencer for the PRESENT-80 key schedule.
- Accepts an 80-bit user key, then iterates the per-round key update 31 times in a register.
- Streams round keys K1..K32, with their round index, to the round datapath over a valid/ready handshake.
- Sits between the key-load interface and the encryption round pipeline. The datapath's key port is fed only by this block.

Parameters:
- KEY_W, 80, user key width. Fixed for PRESENT-80; other values unsupported.
- RK_W, 64, round-key width (top 64 bits of the key register).
- NUM_RK, 32, number of round keys emitted per key load.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- key_in  input  80  user key; sampled on a key handshake.
- key_valid  input  1  user key present.
- key_ready  output  1  scheduler can accept a key (IDLE only).
- rk_data  output  64  current round key = key_reg[79:16].
- rk_round  output  5  round-key index, 1..31, or 0 for K32.
- rk_valid  output  1  rk_data/rk_round valid.
- rk_ready  input  1  datapath consumes the round key.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse when K32 is consumed.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n, sampled on the rising clk edge.
- Reset values:
  - State: IDLE.
  - key_reg = 0, rnd = 1.
  - rk_valid = 0, busy = 0, done = 0, key_ready = 0 during reset.
  - rk_data = 0 and rk_round = 1 follow the registers.
- Reset asserted mid-RUN aborts the sequence immediately. No done is issued and no further rk_valid appears.
- States:
  - IDLE: key_ready = 1. On key_valid & key_ready, load key_reg <= key_in and rnd <= 1, then go to RUN.
  - RUN: rk_valid = 1 and busy = 1.
    - On rk_valid & rk_ready with rnd < 31: key_reg <= update(key_reg, rnd), rnd <= rnd + 1.
    - On handshake with rnd == 31: key_reg <= update(key_reg, 31), rnd <= 0 (this encodes K32).
    - On handshake with rnd == 0: go to DONE.
  - DONE: done = 1 for exactly this one cycle, rk_valid = 0. Next cycle: IDLE.
- Latency:
  - K1 is presented with rk_valid in the cycle after the key handshake.
  - With rk_ready tied high, a new key is presented every cycle: K32 in cycle 32, done in cycle 33, key_ready in cycle 34.
- Backpressure: while rk_valid & !rk_ready, rk_data, rk_round and key_reg hold stable. rk_valid is never deasserted without a handshake.
- update(k, r), combinational, 80-bit, bits numbered 79..0:
  1. t = k rotated left by 61.
  2. t[79:76] = S(t[79:76]), where S = {c,5,6,b,9,0,a,d,3,e,f,8,4,7,1,2} indexed 0..f.
  3. t[19:15] ^= r[4:0].
  - All operations are bitwise. There is no arithmetic addition anywhere.
- rnd wraps 31 -> 0 only as the K32 marker. rnd is never incremented from 0.
- key_valid in RUN or DONE is ignored, because key_ready = 0. The key must be held by the source until accepted.
- A key offered in the same cycle as done is not accepted. It is accepted one cycle later in IDLE.
- rk_ready while rk_valid = 0 has no effect.

Test Plan:
- Reset, then key_in = 0 with key_valid, and rk_ready = 1 throughout. Required:
  - K1 = 0000000000000000 with rk_round 1.
  - K2 = c000000000000000 with rk_round 2.
  - K32 = 6dab31744f41d700 with rk_round 0.
  - done pulses exactly once, one cycle after K32.
- Same key with rk_ready toggling pseudo-randomly. Required: the identical 32-key sequence, rk_data stable during every stall, and exactly 32 handshakes before done.
- key_valid asserted continuously with key_in = ffff_ffffffffffffffff. Required: second key accepted only after done, with key_ready low for all RUN/DONE cycles. First K1 = ffffffffffffffff; the stream matches the golden model.
- rst_n pulsed low for 1 cycle during round 10. Required: next cycle IDLE, rk_valid = 0, no done; a fresh key then restarts at K1.
- Random 80-bit keys (≥200) against a software PRESENT-80 key-schedule model. Required: all 32 round keys and rk_round values match in order.
